// File: rtl/picorv32_dma_copier.sv
// Word-granular memory copy engine acting as a picorv32 native-bus initiator.
// Copies len_words words from src to dst in chunks of up to BURST words,
// reading each chunk into a local buffer before writing it back out.
module picorv32_dma_copier #(
  parameter int unsigned BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len_words,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_done,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(BURST) + 1;
  localparam int unsigned AW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRead   = 2'd1;
  localparam logic [1:0] StWrite  = 2'd2;
  localparam logic [1:0] StFinish = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   src_q, src_d;
  logic [31:0]   dst_q, dst_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [CW-1:0] chunk_q, chunk_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [15:0]   words_done_q, words_done_d;
  logic          error_q, error_d;
  logic          valid_q, valid_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   buf_q [0:(1<<AW)-1];

  logic          xfer;
  logic          last;
  logic [CW-1:0] idx_next;
  logic [15:0]   rem_next;
  logic [31:0]   src_next;
  logic [31:0]   dst_next;

  function automatic logic [CW-1:0] chunk_of(input logic [15:0] n);
    if (n >= 16'(BURST)) return CW'(BURST);
    else                 return CW'(n);
  endfunction

  // Next-state logic: requests only advance on a completing edge, so fields hold while stalled.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    remaining_d  = remaining_q;
    chunk_d      = chunk_q;
    idx_d        = idx_q;
    words_done_d = words_done_q;
    error_d      = 1'b0;
    valid_d      = valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;

    xfer     = valid_q & mem_ready;
    last     = (idx_q == (chunk_q - CW'(1)));
    idx_next = idx_q + CW'(1);
    rem_next = remaining_q - 16'(chunk_q);
    src_next = src_q + (32'(chunk_q) << 2);
    dst_next = dst_q + (32'(chunk_q) << 2);

    case (state_q)
      StIdle: begin
        if (start) begin
          if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
            error_d = 1'b1;
          end else begin
            words_done_d = '0;
            src_d        = src_addr;
            dst_d        = dst_addr;
            remaining_d  = len_words;
            if (len_words == 16'd0) begin
              state_d = StFinish;
            end else begin
              state_d = StRead;
              chunk_d = chunk_of(len_words);
              idx_d   = '0;
              valid_d = 1'b1;
              addr_d  = src_addr;
              wdata_d = '0;
              wstrb_d = 4'b0000;
            end
          end
        end
      end
      StRead: begin
        if (xfer) begin
          if (last) begin
            state_d = StWrite;
            idx_d   = '0;
            addr_d  = dst_q;
            // With a one-word chunk buf[0] is being filled on this very edge.
            wdata_d = (idx_q == '0) ? mem_rdata : buf_q[0];
            wstrb_d = 4'b1111;
          end else begin
            idx_d  = idx_next;
            addr_d = addr_q + 32'd4;
          end
        end
      end
      StWrite: begin
        if (xfer) begin
          words_done_d = words_done_q + 16'd1;
          if (last) begin
            src_d       = src_next;
            dst_d       = dst_next;
            remaining_d = rem_next;
            idx_d       = '0;
            wdata_d     = '0;
            wstrb_d     = 4'b0000;
            if (rem_next != 16'd0) begin
              state_d = StRead;
              chunk_d = chunk_of(rem_next);
              addr_d  = src_next;
            end else begin
              state_d = StFinish;
              valid_d = 1'b0;
            end
          end else begin
            idx_d   = idx_next;
            addr_d  = addr_q + 32'd4;
            wdata_d = buf_q[idx_next[AW-1:0]];
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and bus-field registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      remaining_q  <= '0;
      chunk_q      <= '0;
      idx_q        <= '0;
      words_done_q <= '0;
      error_q      <= 1'b0;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      remaining_q  <= remaining_d;
      chunk_q      <= chunk_d;
      idx_q        <= idx_d;
      words_done_q <= words_done_d;
      error_q      <= error_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  // Chunk buffer capture; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == StRead) && xfer) begin
      buf_q[idx_q[AW-1:0]] <= mem_rdata;
    end
  end

  assign busy       = (state_q == StRead) || (state_q == StWrite);
  assign done       = (state_q == StFinish);
  assign error      = error_q;
  assign words_done = words_done_q;
  assign mem_valid  = valid_q;
  assign mem_instr  = 1'b0;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;

endmodule
